store_buffer: RTL and testbench

- Post-commit store FIFO between the memory stage and the data-SRAM port of the core.
- Accepts retiring stores without stalling the pipeline and drains them to memory one at a time over a req/ack handshake.
- Forwards buffered bytes to younger loads and tells the memory stage when a load must wait for the buffer to drain.
- Back-pressure (`st_ready` low, `ld_conflict` high) feeds `stall_from_memory` in the control block.

---
 rtl/store_buffer.sv | 136 +++++++++++++
 tb/tb_store_buffer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Post-commit store FIFO: drains retired stores to the data SRAM over req/ack
// and forwards buffered bytes to loads. Define STORE_MERGE_EN to merge same-word pushes.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     st_valid,
  input  logic [AW-1:0]            st_addr,
  input  logic [DW-1:0]            st_data,
  input  logic [DW/8-1:0]          st_be,
  output logic                     st_ready,
  input  logic                     ld_valid,
  input  logic [AW-1:0]            ld_addr,
  output logic                     ld_hit,
  output logic [DW-1:0]            ld_data,
  output logic                     ld_conflict,
  output logic                     mem_req,
  output logic [AW-1:0]            mem_addr,
  output logic [DW-1:0]            mem_data,
  output logic [DW/8-1:0]          mem_be,
  input  logic                     mem_ack,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int BW = DW / 8;
  localparam int PW = $clog2(DEPTH);
  localparam int WA = AW - 2;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_REQ  = 1'b1;

  logic [WA-1:0] r_waddr [DEPTH];
  logic [DW-1:0] r_data  [DEPTH];
  logic [BW-1:0] r_be    [DEPTH];
  logic [PW-1:0] r_head, r_tail;
  logic [PW:0]   r_count;
  logic [0:0]    r_state;

  logic          w_full, w_pop, w_push, w_alloc, w_merge_ok, w_merge;
  logic [PW:0]   w_count_nxt;
  logic [BW-1:0] w_union;
  logic [DW-1:0] w_fwd;
  logic          w_unused;

  assign w_unused = ^{st_addr[1:0], ld_addr[1:0]};
  assign w_full   = (r_count == (PW+1)'(DEPTH));
  assign w_pop    = (r_state == S_REQ) && mem_ack;

`ifdef STORE_MERGE_EN
  logic [PW-1:0] w_young;
  assign w_young = r_tail - 1'b1;
  // The head in flight must stay frozen, so it is never a merge target while requested.
  assign w_merge_ok = (r_count != '0) && (r_waddr[w_young] == st_addr[AW-1:2]) &&
                      !((r_state == S_REQ) && (r_count == (PW+1)'(1)));
`else
  assign w_merge_ok = 1'b0;
`endif

  assign st_ready = !w_full || w_merge_ok;
  assign w_push   = st_valid && st_ready;
  assign w_merge  = w_push && w_merge_ok;
  assign w_alloc  = w_push && !w_merge_ok;

  always_comb begin
    w_count_nxt = r_count;
    if (w_alloc && !w_pop)      w_count_nxt = r_count + 1'b1;
    else if (!w_alloc && w_pop) w_count_nxt = r_count - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_state <= S_IDLE;
    end else begin
      r_count <= w_count_nxt;
      if (w_pop)   r_head <= r_head + 1'b1;
      if (w_alloc) r_tail <= r_tail + 1'b1;
      case (r_state)
        S_IDLE:  if (r_count != '0) r_state <= S_REQ;
        default: if (w_pop && (w_count_nxt == '0)) r_state <= S_IDLE;
      endcase
    end
  end

  // Entry payload needs no reset: validity comes from head/count alone.
  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_waddr[r_tail] <= st_addr[AW-1:2];
      r_data[r_tail]  <= st_data;
      r_be[r_tail]    <= st_be;
    end
`ifdef STORE_MERGE_EN
    if (w_merge) begin
      for (int b = 0; b < BW; b++)
        if (st_be[b]) r_data[w_young][8*b +: 8] <= st_data[8*b +: 8];
      r_be[w_young] <= r_be[w_young] | st_be;
    end
`endif
  end

  // Oldest-to-youngest scan so younger stores override older ones per lane.
  always_comb begin
    logic [PW-1:0] v_idx;
    v_idx   = '0;
    w_union = '0;
    w_fwd   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      v_idx = r_head + PW'(i);
      if (((PW+1)'(i) < r_count) && (r_waddr[v_idx] == ld_addr[AW-1:2])) begin
        for (int b = 0; b < BW; b++) begin
          if (r_be[v_idx][b]) begin
            w_fwd[8*b +: 8] = r_data[v_idx][8*b +: 8];
            w_union[b]      = 1'b1;
          end
        end
      end
    end
  end

  assign ld_hit      = ld_valid && (&w_union);
  assign ld_conflict = ld_valid && (|w_union) && !(&w_union);
  assign ld_data     = w_fwd;

  assign mem_req  = (r_state == S_REQ);
  assign mem_addr = mem_req ? {r_waddr[r_head], 2'b00} : '0;
  assign mem_data = mem_req ? r_data[r_head] : '0;
  assign mem_be   = mem_req ? r_be[r_head] : '0;
  assign count    = r_count;
  assign empty    = (r_count == '0);

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: a queue-based reference model checked every
// cycle, plus literal expectations for the documented scenarios.
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st_valid = 1'b0;
  logic [31:0] st_addr  = '0;
  logic [31:0] st_data  = '0;
  logic [3:0]  st_be    = '0;
  logic        st_ready;
  logic        ld_valid = 1'b0;
  logic [31:0] ld_addr  = '0;
  logic        ld_hit;
  logic [31:0] ld_data;
  logic        ld_conflict;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [2:0]  count;
  logic        empty;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_be(st_be),
    .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
    .ld_conflict(ld_conflict),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data), .mem_be(mem_be),
    .mem_ack(mem_ack), .count(count), .empty(empty)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: list of buffered stores (oldest first) plus drain-request flag.
  typedef struct packed {
    logic [29:0] wa;
    logic [31:0] d;
    logic [3:0]  be;
  } ent_t;
  ent_t q[$];
  bit   mreq = 1'b0;

  function automatic bit m_merge_ok();
`ifdef STORE_MERGE_EN
    return (q.size() != 0) && (q[q.size()-1].wa == st_addr[31:2]) && !(mreq && q.size() == 1);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_ready();
    return (q.size() != DEPTH) || m_merge_ok();
  endfunction

  function automatic void m_lookup(input logic [31:0] a, output logic [3:0] u, output logic [31:0] d);
    u = '0;
    d = '0;
    foreach (q[i]) begin
      if (q[i].wa == a[31:2]) begin
        for (int b = 0; b < 4; b++) begin
          if (q[i].be[b]) begin
            d[8*b +: 8] = q[i].d[8*b +: 8];
            u[b] = 1'b1;
          end
        end
      end
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    bit   pop, push, mg;
    int   old;
    ent_t e;
    if (rst) begin
      q.delete();
      mreq = 1'b0;
    end else begin
      old  = q.size();
      pop  = mreq && mem_ack;
      mg   = m_merge_ok();
      push = st_valid && m_ready();
      if (push) begin
        if (mg) begin
          e = q[q.size()-1];
          for (int b = 0; b < 4; b++)
            if (st_be[b]) e.d[8*b +: 8] = st_data[8*b +: 8];
          e.be = e.be | st_be;
          q[q.size()-1] = e;
        end else begin
          q.push_back({st_addr[31:2], st_data, st_be});
        end
      end
      if (pop) void'(q.pop_front());
      if (!mreq) mreq = (old != 0);
      else if (pop) mreq = (q.size() != 0);
    end
  end

  always @(negedge clk) begin
    logic [3:0]  u;
    logic [31:0] d;
    if (rst) begin
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_data", mem_data, 0);
      chk("rst_mem_be", mem_be, 0);
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_st_ready", st_ready, 1);
      chk("rst_ld_hit", ld_hit, 0);
      chk("rst_ld_conflict", ld_conflict, 0);
      chk("rst_ld_data", ld_data, 0);
    end else begin
      chk("mem_req", mem_req, mreq);
      if (mreq) begin
        chk("mem_addr", mem_addr, {q[0].wa, 2'b00});
        chk("mem_data", mem_data, q[0].d);
        chk("mem_be", mem_be, q[0].be);
      end
      chk("count", count, q.size());
      chk("empty", empty, q.size() == 0);
      chk("st_ready", st_ready, m_ready());
      if (ld_valid) begin
        m_lookup(ld_addr, u, d);
        chk("ld_hit", ld_hit, u == 4'hF);
        chk("ld_conflict", ld_conflict, (u != 4'h0) && (u != 4'hF));
        chk("ld_data", ld_data, d);
      end else begin
        chk("ld_hit_idle", ld_hit, 0);
        chk("ld_conflict_idle", ld_conflict, 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_be    = be;
    step();
    st_valid = 1'b0;
  endtask

  task automatic wait_empty(input string nm);
    int i;
    for (i = 0; i < 20 && !empty; i++) step();
    chk(nm, empty, 1);
  endtask

  initial begin
    int i;
    repeat (2) @(posedge clk);
    #1;
    chk("init_count", count, 0);
    chk("init_empty", empty, 1);
    chk("init_st_ready", st_ready, 1);
    chk("init_mem_req", mem_req, 0);
    rst = 1'b0;
    step();

    // Single store, ack tied high: one IDLE cycle, then request, then empty.
    mem_ack = 1'b1;
    push(32'h100, 32'hDEADBEEF, 4'hF);
    chk("t1_idle_cycle", mem_req, 0);
    chk("t1_count1", count, 1);
    step();
    chk("t1_req", mem_req, 1);
    chk("t1_addr", mem_addr, 32'h100);
    chk("t1_data", mem_data, 32'hDEADBEEF);
    step();
    chk("t1_count0", count, 0);
    chk("t1_empty", empty, 1);
    chk("t1_req_done", mem_req, 0);

    // Fill to DEPTH, fifth push held off, one ack frees one slot.
    mem_ack  = 1'b0;
    st_valid = 1'b1;
    st_be    = 4'hF;
    for (int k = 0; k < 4; k++) begin
      st_addr = 32'h10 + 32'(4 * k);
      st_data = 32'hA0000000 + 32'(k);
      step();
    end
    chk("t2_full_count", count, 4);
    chk("t2_full_ready", st_ready, 0);
    st_addr = 32'h20;
    st_data = 32'hA0000004;
    step();
    chk("t2_hold_count", count, 4);
    chk("t2_head_first", mem_addr, 32'h10);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("t2_after_ack_count", count, 3);
    chk("t2_after_ack_ready", st_ready, 1);
    chk("t2_head_second", mem_addr, 32'h14);
    step();
    st_valid = 1'b0;
    chk("t2_refill_count", count, 4);
    mem_ack = 1'b1;
    wait_empty("t2_drain");

    // Forwarding from two partial stores to the same word.
    mem_ack = 1'b0;
    push(32'h200, 32'h11223344, 4'b0011);
    push(32'h200, 32'hAABBCCDD, 4'b1100);
    ld_valid = 1'b1;
    ld_addr  = 32'h200;
    #1;
    chk("t3_hit", ld_hit, 1);
    chk("t3_data", ld_data, 32'hAABB3344);
    chk("t3_no_conflict", ld_conflict, 0);
    ld_addr = 32'h202;
    #1;
    chk("t3_hit_low_bits", ld_hit, 1);
    ld_addr = 32'h204;
    #1;
    chk("t3_miss_hit", ld_hit, 0);
    chk("t3_miss_conflict", ld_conflict, 0);
    ld_valid = 1'b0;
    mem_ack  = 1'b1;
    wait_empty("t3_drain");

    // Partial coverage gives a conflict until the store drains.
    mem_ack = 1'b0;
    push(32'h300, 32'h000000A5, 4'b0001);
    ld_valid = 1'b1;
    ld_addr  = 32'h300;
    #1;
    chk("t4_conflict", ld_conflict, 1);
    chk("t4_no_hit", ld_hit, 0);
    chk("t4_partial_data", ld_data, 32'h000000A5);
    step();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("t4_conflict_cleared", ld_conflict, 0);
    chk("t4_count", count, 0);
    ld_valid = 1'b0;

    // Request held stable while unacknowledged, then async reset drops it.
    push(32'h500, 32'h12345678, 4'hF);
    step();
    for (int k = 0; k < 5; k++) begin
      chk("t5_req", mem_req, 1);
      chk("t5_addr", mem_addr, 32'h500);
      chk("t5_data", mem_data, 32'h12345678);
      chk("t5_be", mem_be, 4'hF);
      if (k == 0) begin
        st_valid = 1'b1;
        st_addr  = 32'h504;
        st_data  = 32'h0BADF00D;
      end
      step();
      st_valid = 1'b0;
    end
    rst = 1'b1;
    #1;
    chk("t5_rst_req", mem_req, 0);
    chk("t5_rst_count", count, 0);
    chk("t5_rst_addr", mem_addr, 0);
    chk("t5_rst_empty", empty, 1);
    step();
    rst = 1'b0;
    step();

    // Full buffer with youngest 0x400 not in flight: merge or stall.
    push(32'h600, 32'h06060606, 4'hF);
    push(32'h604, 32'h16161616, 4'hF);
    push(32'h608, 32'h26262626, 4'hF);
    push(32'h400, 32'h44332211, 4'b0111);
    chk("t6_full", count, 4);
    st_valid = 1'b1;
    st_addr  = 32'h400;
    st_data  = 32'h77000000;
    st_be    = 4'b1000;
    #1;
`ifdef STORE_MERGE_EN
    chk("t6_merge_ready", st_ready, 1);
`else
    chk("t6_stall_ready", st_ready, 0);
`endif
    step();
    st_valid = 1'b0;
    chk("t6_count", count, 4);
    mem_ack = 1'b1;
    for (i = 0; i < 20 && !(mem_req && mem_addr == 32'h400); i++) step();
    chk("t6_reached_0x400", i < 20, 1);
`ifdef STORE_MERGE_EN
    chk("t6_merged_data", mem_data, 32'h77332211);
    chk("t6_merged_be", mem_be, 4'hF);
`else
    chk("t6_plain_data", mem_data, 32'h44332211);
    chk("t6_plain_be", mem_be, 4'b0111);
`endif
    wait_empty("t6_drain");
    mem_ack = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
